// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one delay counter among four requesters.
// The owner is timed for its latched delay, then gets a one-cycle done pulse.
module delay_timer_arbiter #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] delay0,
    input  logic [WIDTH-1:0] delay1,
    input  logic [WIDTH-1:0] delay2,
    input  logic [WIDTH-1:0] delay3,
    output logic [3:0]       grant,
    output logic [3:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] desired
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       owner_q;
    logic [1:0]       last_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] desired_q;
    logic [3:0]       grant_q;
    logic [3:0]       done_q;

    logic             winnerValid_d;
    logic [1:0]       winnerIdx_d;
    logic [1:0]       searchIdx;
    logic [WIDTH-1:0] winnerDelay_d;

    // Scan from the farthest candidate to the nearest so that the requester
    // closest after last_q overwrites the others and wins.
    always_comb begin
        winnerValid_d = 1'b0;
        winnerIdx_d   = 2'd0;
        searchIdx     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            searchIdx = last_q + 2'(i + 1);
            if (req[searchIdx]) begin
                winnerValid_d = 1'b1;
                winnerIdx_d   = searchIdx;
            end
        end
    end

    always_comb begin
        case (winnerIdx_d)
            2'd0:    winnerDelay_d = delay0;
            2'd1:    winnerDelay_d = delay1;
            2'd2:    winnerDelay_d = delay2;
            default: winnerDelay_d = delay3;
        endcase
    end

    // An abort (owner drops its request) takes precedence over completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            count_q   <= '0;
            desired_q <= '0;
            grant_q   <= 4'b0000;
            done_q    <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 4'b0000;
                    if (winnerValid_d) begin
                        state_q   <= COUNT;
                        owner_q   <= winnerIdx_d;
                        desired_q <= winnerDelay_d;
                        count_q   <= '0;
                        grant_q   <= 4'b0001 << winnerIdx_d;
                    end
                end
                COUNT: begin
                    if (!req[owner_q]) begin
                        state_q <= IDLE;
                        grant_q <= 4'b0000;
                        last_q  <= owner_q;
                    end else if (count_q < desired_q) begin
                        count_q <= count_q + WIDTH'(1);
                    end else begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 4'b0000;
                    grant_q <= 4'b0000;
                    last_q  <= owner_q;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 4'b0000;
                    grant_q <= 4'b0000;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign count   = count_q;
    assign desired = desired_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Testbench for delay_timer_arbiter: directed scenarios plus randomized traffic
// compared against an elapsed-time transaction model of the arbiter.
module tb_delay_timer_arbiter;

    localparam int W = 30;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] delay0 = '0;
    logic [W-1:0] delay1 = '0;
    logic [W-1:0] delay2 = '0;
    logic [W-1:0] delay3 = '0;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic [W-1:0] count;
    logic [W-1:0] desired;

    int checks = 0;
    int passes = 0;

    // Model state: owner index (-1 none), cycles since grant, latched delay.
    int mOwner = -1;
    int mLast = 3;
    int mT = 0;
    int mD = 0;
    int mHeld = 0;
    int mDes = 0;

    delay_timer_arbiter #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .delay0(delay0),
        .delay1(delay1),
        .delay2(delay2),
        .delay3(delay3),
        .grant(grant),
        .done(done),
        .busy(busy),
        .count(count),
        .desired(desired)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelStep();
        int dl[4];
        dl[0] = int'(delay0);
        dl[1] = int'(delay1);
        dl[2] = int'(delay2);
        dl[3] = int'(delay3);
        if (reset) begin
            mOwner = -1;
            mLast  = 3;
            mHeld  = 0;
            mDes   = 0;
        end else if (mOwner < 0) begin
            if (req != 4'b0000) begin
                for (int j = 1; j <= 4; j++) begin
                    if (req[(mLast + j) % 4]) begin
                        mOwner = (mLast + j) % 4;
                        break;
                    end
                end
                mD   = dl[mOwner];
                mDes = mD;
                mT   = 0;
            end
        end else if (mT == mD + 1) begin
            mHeld  = mD;
            mLast  = mOwner;
            mOwner = -1;
        end else if (!req[mOwner]) begin
            mHeld  = (mT < mD) ? mT : mD;
            mLast  = mOwner;
            mOwner = -1;
        end else begin
            mT++;
        end
    endtask

    function automatic logic [3:0] expGrant();
        return (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    endfunction

    function automatic logic [3:0] expDone();
        return (mOwner >= 0 && mT == mD + 1) ? expGrant() : 4'b0000;
    endfunction

    function automatic logic [W-1:0] expCount();
        if (mOwner >= 0) return W'((mT < mD) ? mT : mD);
        return W'(mHeld);
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== '0 || desired !== '0)
            $display("[TB] FAIL reset_state: grant=%b done=%b busy=%b count=%0d desired=%0d, want all zero",
                     grant, done, busy, count, desired);
        else passes++;
    endtask

    task automatic test_single();
        int n = 0;
        int peak = 0;
        applyReset();
        delay0 = W'(5);
        req    = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) $display("[TB] FAIL single_grant: grant=%b busy=%b, want 0001 1", grant, busy);
        else passes++;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (int'(count) > peak) peak = int'(count);
            if (done != 4'b0000) break;
        end
        checks++;
        if (n != 6 || done !== 4'b0001) $display("[TB] FAIL single_latency: cycles=%0d done=%b, want 6 0001", n, done);
        else passes++;
        checks++;
        if (peak != 5) $display("[TB] FAIL single_peak: count peak=%0d, want 5", peak);
        else passes++;
        req = 4'b0000;
        tick();
        checks++;
        if (done !== 4'b0000 || grant !== 4'b0000) $display("[TB] FAIL single_pulse: done=%b grant=%b, want 0000 0000", done, grant);
        else passes++;
    endtask

    task automatic test_round_robin();
        logic [3:0] want[5];
        logic [3:0] got[5];
        int gCyc[5];
        int gi = 0;
        int zeros = 0;
        logic [3:0] prev = 4'b0000;
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        applyReset();
        delay0 = W'(2); delay1 = W'(2); delay2 = W'(2); delay3 = W'(2);
        req = 4'b1111;
        for (int c = 0; c < 60 && gi < 5; c++) begin
            tick();
            if (grant == 4'b0000 && gi > 0) zeros++;
            if (grant != 4'b0000 && prev == 4'b0000) begin
                got[gi]  = grant;
                gCyc[gi] = c;
                gi++;
            end
            if (done != 4'b0000 && gi > 0) begin
                checks++;
                if (done !== grant || c - gCyc[gi-1] != 3)
                    $display("[TB] FAIL rr_done: done=%b grant=%b delay=%0d, want done==grant after 3", done, grant, c - gCyc[gi-1]);
                else passes++;
            end
            prev = grant;
        end
        checks++;
        if (gi != 5) $display("[TB] FAIL rr_count: grants seen=%0d, want 5", gi);
        else passes++;
        for (int i = 0; i < gi; i++) begin
            checks++;
            if (got[i] !== want[i]) $display("[TB] FAIL rr_order[%0d]: got %b, want %b", i, got[i], want[i]);
            else passes++;
            if (i > 0) begin
                checks++;
                if (gCyc[i] - gCyc[i-1] != 5) $display("[TB] FAIL rr_spacing[%0d]: %0d cycles, want 5", i, gCyc[i] - gCyc[i-1]);
                else passes++;
            end
        end
        checks++;
        if (zeros != 4) $display("[TB] FAIL rr_idle: idle grant cycles=%0d, want 4", zeros);
        else passes++;
        req = 4'b0000;
    endtask

    task automatic test_zero_delay();
        applyReset();
        delay2 = '0;
        req    = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || count !== '0) $display("[TB] FAIL zero_grant: grant=%b count=%0d, want 0100 0", grant, count);
        else passes++;
        tick();
        checks++;
        if (done !== 4'b0100 || count !== '0) $display("[TB] FAIL zero_done: done=%b count=%0d, want 0100 0", done, count);
        else passes++;
        req = 4'b0000;
        tick();
        checks++;
        if (done !== 4'b0000 || grant !== 4'b0000) $display("[TB] FAIL zero_after: done=%b grant=%b, want 0000 0000", done, grant);
        else passes++;
    endtask

    task automatic test_abort();
        applyReset();
        delay1 = W'(100);
        req    = 4'b0010;
        tick();
        for (int i = 0; i < 60 && count != W'(40); i++) tick();
        checks++;
        if (count !== W'(40) || grant !== 4'b0010) $display("[TB] FAIL abort_reach: count=%0d grant=%b, want 40 0010", count, grant);
        else passes++;
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== W'(40))
            $display("[TB] FAIL abort_stop: grant=%b done=%b busy=%b count=%0d, want 0000 0000 0 40", grant, done, busy, count);
        else passes++;
        tick();
        checks++;
        if (count !== W'(40) || done !== 4'b0000) $display("[TB] FAIL abort_frozen: count=%0d done=%b, want 40 0000", count, done);
        else passes++;
        req = 4'b0011;
        tick();
        checks++;
        if (grant !== 4'b0001) $display("[TB] FAIL abort_rr: grant=%b, want 0001", grant);
        else passes++;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        applyReset();
        delay0 = W'(20);
        req    = 4'b0001;
        tick();
        for (int i = 0; i < 30 && count != W'(7); i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== '0 || desired !== '0)
            $display("[TB] FAIL midreset_clear: grant=%b done=%b busy=%b count=%0d desired=%0d, want all zero",
                     grant, done, busy, count, desired);
        else passes++;
        reset = 1'b0;
        req   = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000) $display("[TB] FAIL midreset_grant: grant=%b, want 1000", grant);
        else passes++;
        applyReset();
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0001) $display("[TB] FAIL reset_priority: grant=%b, want 0001", grant);
        else passes++;
        req = 4'b0000;
    endtask

    task automatic test_delay_change();
        int n = 0;
        applyReset();
        delay0 = W'(10);
        req    = 4'b0001;
        tick();
        for (int i = 0; i < 20 && count != W'(2); i++) begin
            tick();
            n++;
        end
        delay0 = W'(3);
        for (int i = 0; i < 40 && done == 4'b0000; i++) begin
            tick();
            n++;
        end
        checks++;
        if (n != 11 || done !== 4'b0001 || desired !== W'(10))
            $display("[TB] FAIL latch_delay: cycles=%0d done=%b desired=%0d, want 11 0001 10", n, done, desired);
        else passes++;
        req = 4'b0000;
    endtask

    task automatic test_random();
        applyReset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) delay0 = W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) delay1 = W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) delay2 = W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) delay3 = W'($urandom_range(0, 7));
            tick();
            checks++;
            if (grant !== expGrant() || done !== expDone() || busy !== (mOwner >= 0))
                $display("[TB] FAIL rand_ctrl@%0d: grant=%b done=%b busy=%b, want %b %b %b",
                         c, grant, done, busy, expGrant(), expDone(), mOwner >= 0);
            else passes++;
            checks++;
            if (count !== expCount() || desired !== W'(mDes))
                $display("[TB] FAIL rand_data@%0d: count=%0d desired=%0d, want %0d %0d",
                         c, count, desired, expCount(), mDes);
            else passes++;
        end
        reset = 1'b0;
        req   = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_delay();
        test_abort();
        test_reset_mid();
        test_delay_change();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
